// File: rtl/adv7511_init_sequencer.sv
// adv7511_init_sequencer: walks the ADV7511 register table over the I2C master after hot-plug,
// with per-entry NACK retry, then enables video timing.
module adv7511_init_sequencer #(
  parameter int NBYTES       = 3,
  parameter int NTRANS       = 10,
  parameter int POWERUP_WAIT = 1000,
  parameter int GAP_CYCLES   = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      hpd_i,
  input  logic                      restart_i,
  output logic [$clog2(NTRANS)-1:0] rom_addr_o,
  input  logic [8*NBYTES-1:0]       rom_data_i,
  output logic                      cmd_valid_o,
  input  logic                      cmd_ready_i,
  output logic [8*NBYTES-1:0]       cmd_data_o,
  input  logic                      done_i,
  input  logic                      nack_i,
  output logic                      busy_o,
  output logic                      init_done_o,
  output logic                      video_en_o,
  output logic                      error_o
);
  localparam int IW = $clog2(NTRANS);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int CW = $clog2((POWERUP_WAIT > GAP_CYCLES ? POWERUP_WAIT : GAP_CYCLES) + 1);
  typedef enum logic [3:0] {IDLE, WAIT_PWR, FETCH1, FETCH2, ISSUE, WAIT_DONE, GAP, DONE, ERROR} state_t;
  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                abort_q, abort_d;
  logic                to_fetch_q, to_fetch_d;
  logic [8*NBYTES-1:0] data_q, data_d;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      retry_q    <= '0;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      to_fetch_q <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      to_fetch_q <= to_fetch_d;
      data_q     <= data_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    cnt_d      = cnt_q;
    abort_d    = abort_q;
    to_fetch_d = to_fetch_q;
    data_d     = data_q;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (hpd_i) begin
          state_d = WAIT_PWR;
          cnt_d   = CW'(POWERUP_WAIT - 1);
        end
      end
      WAIT_PWR:
        if (!hpd_i) state_d = IDLE;
        else if (cnt_q == '0) begin
          state_d = FETCH1;
          idx_d   = '0;
          retry_d = '0;
        end else cnt_d = cnt_q - CW'(1);
      FETCH1: state_d = hpd_i ? FETCH2 : IDLE;
      FETCH2:
        if (!hpd_i) state_d = IDLE;
        else begin
          data_d  = rom_data_i;
          state_d = ISSUE;
        end
      // Hot-plug loss during a command only marks abort; the master is always allowed to finish.
      ISSUE: begin
        if (!hpd_i) abort_d = 1'b1;
        if (cmd_ready_i) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!hpd_i) abort_d = 1'b1;
        if (done_i) begin
          if (abort_q || !hpd_i) state_d = IDLE;
          else if (!nack_i) begin
            if (idx_q == IW'(NTRANS - 1)) state_d = DONE;
            else begin
              idx_d      = idx_q + IW'(1);
              retry_d    = '0;
              to_fetch_d = 1'b1;
              cnt_d      = CW'(GAP_CYCLES - 1);
              state_d    = GAP;
            end
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d    = retry_q + RW'(1);
            to_fetch_d = 1'b0;
            cnt_d      = CW'(GAP_CYCLES - 1);
            state_d    = GAP;
          end else state_d = ERROR;
        end
      end
      GAP:
        if (!hpd_i) state_d = IDLE;
        else if (cnt_q == '0) state_d = to_fetch_q ? FETCH1 : ISSUE;
        else cnt_d = cnt_q - CW'(1);
      DONE, ERROR: if (!hpd_i || restart_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign rom_addr_o  = idx_q;
  assign cmd_data_o  = data_q;
  assign cmd_valid_o = state_q == ISSUE;
  assign busy_o      = state_q inside {WAIT_PWR, FETCH1, FETCH2, ISSUE, WAIT_DONE, GAP};
  assign init_done_o = state_q == DONE;
  assign video_en_o  = state_q == DONE;
  assign error_o     = state_q == ERROR;
endmodule

// File: tb/tb_adv7511_init_sequencer.sv
// tb_adv7511_init_sequencer: directed and randomized runs of the init sequencer against a
// transaction-level model of the table walk, retry budget and inter-command timing.
module tb_adv7511_init_sequencer;
  localparam int NT = 3, PW = 20, GAPC = 4, MAXR = 3;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, hpd = 1'b0, restart = 1'b0;
  logic [1:0]  rom_addr;
  logic [23:0] rom_data = '0, cmd_data;
  logic        cmd_valid, cmd_ready = 1'b0, done = 1'b0, nack = 1'b0;
  logic        busy, init_done, video_en, error_o;
  logic [23:0] rom_m [4];
  int          nacks [NT];
  int          bp [NT];
  int          errors = 0, checks = 0;
  adv7511_init_sequencer #(.NBYTES(3), .NTRANS(NT), .POWERUP_WAIT(PW), .GAP_CYCLES(GAPC), .MAX_RETRY(MAXR)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .hpd_i(hpd), .restart_i(restart),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_data_o(cmd_data),
    .done_i(done), .nack_i(nack), .busy_o(busy), .init_done_o(init_done),
    .video_en_o(video_en), .error_o(error_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom_m[rom_addr];
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (cmd_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask
  function automatic int model_cmds();
    int c = 0;
    for (int e = 0; e < NT; e++) begin
      if (nacks[e] > MAXR) return c + MAXR + 1;
      c += nacks[e] + 1;
    end
    return c;
  endfunction
  function automatic bit model_err();
    for (int e = 0; e < NT; e++) if (nacks[e] > MAXR) return 1'b1;
    return 1'b0;
  endfunction
  task automatic clear_cfg();
    for (int e = 0; e < NT; e++) begin
      nacks[e] = 0;
      bp[e] = 0;
    end
  endtask
  task automatic run_seq(input int drop_ent, input int rst_ent);
    int  ent, tries, n, ncmd, egap;
    bit  fin, seen;
    hpd = 1'b1;
    wait_valid(n);
    chk("pwr_latency", n, PW + 3);
    ent = 0; tries = 0; ncmd = 0; fin = 1'b0;
    while (!fin) begin
      chk("rom_addr", rom_addr, ent);
      chk("cmd_data", cmd_data, rom_m[ent]);
      chk("busy_issue", busy, 1);
      ncmd++;
      if (ent == rst_ent) begin
        repeat (2) begin
          tick();
          chk("pre_rst_valid", cmd_valid, 1);
        end
        rst_n = 1'b0;
        tick();
        chk("rst_outputs", {cmd_valid, busy, init_done, video_en, error_o, rom_addr, cmd_data}, 0);
        rst_n = 1'b1;
        return;
      end
      for (int k = 0; k < bp[ent]; k++) begin
        tick();
        chk("bp_valid", cmd_valid, 1);
        chk("bp_data", cmd_data, rom_m[ent]);
      end
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk("valid_drop", cmd_valid, 0);
      if (ent == drop_ent) begin
        hpd = 1'b0;
        repeat (3) begin
          tick();
          chk("abort_busy", busy, 1);
        end
        done = 1'b1; nack = 1'($urandom);
        tick();
        done = 1'b0; nack = 1'b0;
        seen = 1'b0;
        repeat (10) begin
          seen |= cmd_valid;
          tick();
        end
        chk("abort_novalid", seen, 0);
        chk("abort_idle", {busy, init_done, error_o}, 0);
        return;
      end
      repeat ($urandom_range(0, 3)) tick();
      done = 1'b1; nack = tries < nacks[ent];
      tick();
      if (nack) begin
        if (tries == MAXR) fin = 1'b1;
        else begin
          tries++;
          egap = GAPC;
        end
      end else if (ent == NT - 1) fin = 1'b1;
      else begin
        ent++;
        tries = 0;
        egap = GAPC + 2;
      end
      done = 1'b0; nack = 1'b0;
      if (fin) begin
        chk("term_error", error_o, model_err());
        chk("term_init_done", init_done, !model_err());
        chk("term_video_en", video_en, !model_err());
        chk("term_busy", busy, 0);
      end else begin
        wait_valid(n);
        chk("gap_len", n, egap);
      end
    end
    chk("cmd_count", ncmd, model_cmds());
  endtask
  task automatic leave(input bit use_restart);
    if (use_restart) restart = 1'b1;
    else hpd = 1'b0;
    tick();
    restart = 1'b0;
    chk("leave_clear", {init_done, video_en, error_o, busy}, 0);
  endtask
  initial begin
    rom_m[0] = 24'h724110; rom_m[1] = 24'h729803; rom_m[2] = 24'h721500; rom_m[3] = 24'h0;
    clear_cfg();
    repeat (3) tick();
    chk("reset_state", {cmd_valid, busy, init_done, video_en, error_o, rom_addr, cmd_data}, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_hpd", busy, 0);
    run_seq(-1, -1);
    leave(1'b0);
    bp[1] = 7;
    run_seq(-1, -1);
    leave(1'b0);
    clear_cfg();
    nacks[1] = 1;
    run_seq(-1, -1);
    leave(1'b0);
    clear_cfg();
    nacks[0] = MAXR + 1;
    run_seq(-1, -1);
    leave(1'b1);
    clear_cfg();
    run_seq(-1, -1);
    leave(1'b0);
    run_seq(1, -1);
    run_seq(-1, -1);
    leave(1'b0);
    run_seq(-1, 1);
    run_seq(-1, -1);
    leave(1'b0);
    for (int it = 0; it < 8; it++) begin
      for (int e = 0; e < NT; e++) begin
        rom_m[e] = 24'($urandom);
        nacks[e] = ($urandom_range(0, 5) == 0) ? MAXR + 1 : $urandom_range(0, 2);
        bp[e] = $urandom_range(0, 4);
      end
      run_seq(-1, -1);
      leave(1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
